main_control_fsm: RTL
=====================

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 SHALL have parameter STATE_W, default 4, width of the state register and State output.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Op  input  6  instruction opcode from the IR.
REQ-005 SHALL have 1-bit outputs PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst, Illegal_Op.
REQ-006 SHALL have 2-bit outputs ALU_OP (feeds the ALU control decoder: 00 add, 01 subtract, 10 use Func), ALUSrcB and PCSource.
REQ-007 SHALL have output State  STATE_W bits  current state, for debug.

Function
REQ-008 SHALL be a Moore FSM; every output SHALL be decoded only from the registered state.
REQ-009 SHALL encode states as FETCH=0, DECODE=1, MEMADDR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
REQ-010 FETCH SHALL drive MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALU_OP=00, PCWrite=1, PCSource=00, then go to DECODE.
REQ-011 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALU_OP=00, then branch on Op: 100011 or 101011 -> MEMADDR, 000000 -> EXECUTE, 000100 -> BRANCH, 000010 -> JUMP, 001000 -> ADDIEX, any other -> FETCH.
REQ-012 MEMADDR SHALL drive ALUSrcA=1, ALUSrcB=10, ALU_OP=00, then go to MEMREAD if Op=100011, else MEMWRITE.
REQ-013 MEMREAD SHALL drive MemRead=1, IorD=1 -> MEMWB; MEMWB SHALL drive RegWrite=1, RegDst=0, MemtoReg=1 -> FETCH.
REQ-014 MEMWRITE SHALL drive MemWrite=1, IorD=1 -> FETCH.
REQ-015 EXECUTE SHALL drive ALUSrcA=1, ALUSrcB=00, ALU_OP=10 -> RWB; RWB SHALL drive RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
REQ-016 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALU_OP=01, PCWriteCond=1, PCSource=01 -> FETCH.
REQ-017 JUMP SHALL drive PCWrite=1, PCSource=10 -> FETCH.
REQ-018 ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=10, ALU_OP=00 -> ADDIWB; ADDIWB SHALL drive RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
REQ-019 Every output not listed for a state SHALL be 0 in that state.
REQ-020 Illegal_Op SHALL be 1 only in DECODE when Op matches no decoded opcode.
REQ-021 Unused encodings 12..15 SHALL transition to FETCH with all outputs 0.
REQ-022 Op SHALL be sampled only in DECODE and MEMADDR; its value in other states SHALL have no effect.
REQ-023 Per-instruction cycle counts SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.

Reset
REQ-024 Assertion of rst_n=0 SHALL set the state to FETCH immediately, regardless of clk, including mid-instruction.
REQ-025 While rst_n=0, every output except State SHALL be forced to 0, with State=0.
REQ-026 The first rising clk edge after rst_n rises SHALL complete FETCH and enter DECODE.

Configuration
REQ-027 Macro MAIN_CTRL_ADDI_EN SHALL compile in addi support.
REQ-028 With MAIN_CTRL_ADDI_EN defined, addi SHALL follow REQ-011 and REQ-018.
REQ-029 Without MAIN_CTRL_ADDI_EN, opcode 001000 SHALL be treated as illegal, and ADDIEX/ADDIWB SHALL behave as unused encodings.

Structure
REQ-030 A shared package SHALL hold the state encodings, the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI) and the ALU_OP codes.
REQ-031 The design SHALL use one sub-module, main_control_decode, a combinational state-to-outputs decoder.

Verification
REQ-032 Reset pulse mid-MEMREAD -> State=0 with all outputs 0 during reset; after release, FETCH outputs for 1 cycle, then DECODE.
REQ-033 Op=100011 -> State sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-034 Op=000000 -> sequence 0,1,6,7,0; ALU_OP=10 in state 6; RegDst=1 in state 7.
REQ-035 Op=000100, then Op=000010 -> sequences 0,1,8,0 with ALU_OP=01 and PCSource=01, then 0,1,9,0 with PCWrite=1 and PCSource=10.
REQ-036 Op=111111 -> Illegal_Op=1 for 1 cycle in state 1, then state 0; no write enable asserted.
REQ-037 Op=001000 with the macro defined -> sequence 0,1,10,11,0; without it -> 0,1,0 with Illegal_Op=1.

Source files
------------

// File: rtl/main_control_fsm_pkg.sv
// Shared definitions for the multi-cycle main control FSM.
// Holds state encodings, opcode constants, ALU_OP codes, mux-select codes,
// the packed control-word struct and an opcode legality helper.
// Optional feature macro: MAIN_CTRL_ADDI_EN (compiles in addi support).
package main_control_fsm_pkg;

  localparam int unsigned StateBits = 4;

  typedef enum logic [StateBits-1:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StRwb      = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StAddiEx   = 4'd10,
    StAddiWb   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_OP_ADD  = 2'b00;
  localparam logic [1:0] ALU_OP_SUB  = 2'b01;
  localparam logic [1:0] ALU_OP_FUNC = 2'b10;

  localparam logic [1:0] SRCB_REG       = 2'b00;
  localparam logic [1:0] SRCB_FOUR      = 2'b01;
  localparam logic [1:0] SRCB_IMM       = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHIFT = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic       illegal_op;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
  } ctrl_t;

  function automatic logic op_is_legal(input logic [5:0] op);
    logic legal;
    legal = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
            (op == OP_BEQ) || (op == OP_J);
`ifdef MAIN_CTRL_ADDI_EN
    legal = legal || (op == OP_ADDI);
`endif
    return legal;
  endfunction

endpackage

// File: rtl/main_control_decode.sv
// Combinational state-to-control-word decoder for the main control FSM.
// Ports:
//   state - current registered state
//   op    - instruction opcode, only consulted in DECODE to flag illegal ops
//   ctrl  - full control word; fields not driven by a state stay 0
// Optional feature macro: MAIN_CTRL_ADDI_EN (decodes ADDIEX/ADDIWB).
module main_control_decode
  import main_control_fsm_pkg::*;
(
  input  state_e      state,
  input  logic [5:0]  op,
  output ctrl_t       ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_ALU;
      end
      StDecode: begin
        ctrl.alu_src_b  = SRCB_IMM_SHIFT;
        ctrl.alu_op     = ALU_OP_ADD;
        ctrl.illegal_op = ~op_is_legal(op);
      end
      StMemAddr: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      StMemRead: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      StMemWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      StMemWrite: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      StExecute: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_OP_FUNC;
      end
      StRwb: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      StBranch: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_OP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      StJump: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
`ifdef MAIN_CTRL_ADDI_EN
      StAddiEx: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      StAddiWb: begin
        ctrl.reg_write = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Moore main control FSM for a multi-cycle MIPS-style datapath.
// Ports:
//   clk, rst_n   - clock (rising edge) and asynchronous active-low reset
//   Op           - opcode from IR, sampled only in DECODE and MEMADDR
//   PCWrite .. Illegal_Op, ALU_OP, ALUSrcB, PCSource - datapath controls
//   State        - current state (debug), STATE_W bits
// Optional feature macro: MAIN_CTRL_ADDI_EN (addi support; otherwise addi
// is illegal and ADDIEX/ADDIWB act as unused encodings).
module main_control_fsm
  import main_control_fsm_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         Op,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic               ALUSrcA,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               Illegal_Op,
  output logic [1:0]         ALU_OP,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [STATE_W-1:0] State
);

  state_e state_q, state_d;
  ctrl_t  ctrl, ctrl_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        case (Op)
          OP_LW, OP_SW: state_d = StMemAddr;
          OP_RTYPE:     state_d = StExecute;
          OP_BEQ:       state_d = StBranch;
          OP_J:         state_d = StJump;
`ifdef MAIN_CTRL_ADDI_EN
          OP_ADDI:      state_d = StAddiEx;
`endif
          default:      state_d = StFetch;
        endcase
      end
      StMemAddr:  state_d = (Op == OP_LW) ? StMemRead : StMemWrite;
      StMemRead:  state_d = StMemWb;
      StExecute:  state_d = StRwb;
`ifdef MAIN_CTRL_ADDI_EN
      StAddiEx:   state_d = StAddiWb;
`endif
      default:    state_d = StFetch;
    endcase
  end

  main_control_decode u_decode (
    .state (state_q),
    .op    (Op),
    .ctrl  (ctrl)
  );

  // FETCH would otherwise assert PC/IR writes while reset is held.
  assign ctrl_out = rst_n ? ctrl : '0;

  assign PCWrite     = ctrl_out.pc_write;
  assign PCWriteCond = ctrl_out.pc_write_cond;
  assign IorD        = ctrl_out.i_or_d;
  assign MemRead     = ctrl_out.mem_read;
  assign MemWrite    = ctrl_out.mem_write;
  assign MemtoReg    = ctrl_out.mem_to_reg;
  assign IRWrite     = ctrl_out.ir_write;
  assign ALUSrcA     = ctrl_out.alu_src_a;
  assign RegWrite    = ctrl_out.reg_write;
  assign RegDst      = ctrl_out.reg_dst;
  assign Illegal_Op  = ctrl_out.illegal_op;
  assign ALU_OP      = ctrl_out.alu_op;
  assign ALUSrcB     = ctrl_out.alu_src_b;
  assign PCSource    = ctrl_out.pc_source;
  assign State       = STATE_W'(state_q);

endmodule
